hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the forwarding unit and decides, each cycle, whether the front end (PC, IF/ID) stalls, whether a bubble enters ID/EX, and whether IF/ID is flushed. It covers:

- load-use hazards;
- branch/jump-register operands that the EX/MEM compare forwarding cannot yet supply;
- waits on the multiply/divide unit;
- external interrupt entry.

It also keeps saturating stall/flush statistics counters.

## Interface
Parameters:
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- IFID_rs, IFID_rt  in  5 each  source registers of the instruction in ID
- IFID_usert  in  1  ID instruction reads rt
- IFID_pcsrc  in  3  ID PC source: 000 seq, 001 branch, 010 jump, 011 jump register
- IFID_usehilo  in  1  ID instruction reads HI/LO or starts mult/div
- branch_taken  in  1  ID-stage compare/jump resolution says redirect
- IDEX_wraddr  in  5  destination register of the EX instruction
- IDEX_regwr, IDEX_memrd  in  1 each
- EXMEM_wraddr  in  5  destination register of the MEM instruction
- EXMEM_regwr, EXMEM_memrd  in  1 each
- md_busy  in  1  mult/div unit busy
- irq  in  1  level interrupt request
- cnt_clr  in  1  clear the statistics counters
- PC_stall, IFID_stall  out  1  hold PC / IF/ID
- IDEX_bubble  out  1  load a NOP into ID/EX
- IFID_flush  out  1  load a NOP into IF/ID
- irq_take  out  1  PC loads the exception vector; the ID instruction's PC is saved as EPC
- stall_cnt, flush_cnt  out  CNT_W each  statistics

## Operation
Hazard terms (combinational; a register address of 0 never matches):
- **lu**: IDEX_memrd and IDEX_wraddr matches IFID_rs, or matches IFID_rt when IFID_usert.
- **br**: IFID_pcsrc is 001 or 011, and either of these matches IFID_rs, or IFID_rt when IFID_usert:
  - IDEX_wraddr with IDEX_regwr, or
  - EXMEM_wraddr with EXMEM_memrd.
- **md**: IFID_usehilo and md_busy.
- **haz** = lu | br | md.

FSM states: RUN, MD_WAIT, IRQ_WAIT. Reset enters RUN.

- **RUN**
  - If haz: assert PC_stall, IFID_stall and IDEX_bubble this cycle. Stay in RUN, except go to MD_WAIT when md and not (lu | br).
  - Else if irq and IFID_pcsrc==000:
    - assert irq_take and IFID_flush, plus IDEX_bubble;
    - go to IRQ_WAIT.
  - Else if branch_taken: assert IFID_flush.
  - Else: all outputs low.
- **MD_WAIT**
  - Assert PC_stall, IFID_stall and IDEX_bubble while md_busy.
  - When md_busy is low, deassert all three and return to RUN in the same cycle; the hazard terms are re-evaluated in RUN from the next cycle.
  - irq is ignored in this state.
- **IRQ_WAIT**
  - Normal hazard handling as in RUN, but new interrupts are not taken.
  - Return to RUN the cycle after irq is sampled low.

Rules:
- Stalls never flush. branch_taken is ignored while haz is asserted, because the compare operands are stale.
- An interrupt is never taken while ID holds a branch or jump, so a redirect target is never lost.

Counters:
- stall_cnt increments each cycle PC_stall is high.
- flush_cnt increments each cycle IFID_flush is high.
- Both saturate at all-ones.
- cnt_clr zeroes both and takes priority over increment.

## Timing
- Stall, bubble, flush and irq_take are combinational (Mealy) from the registered pipeline fields and the state register. They are valid in the same cycle the hazard is visible.
- Reset (synchronous): state=RUN, counters=0. All control outputs are low in the reset cycle and the cycle after, independent of inputs.
- Reset during MD_WAIT or IRQ_WAIT returns to RUN with no pending stall.
- Stall length:
  - load-use: 1 cycle;
  - branch on an EX ALU result: 1 cycle;
  - branch on an EX load: 2 cycles (EX-load term, then EXMEM-load term);
  - branch on a MEM load: 1 cycle;
  - md: until md_busy falls.
- Counters update on the clock edge following the qualifying cycle.

## Test plan
- lw $2 in EX, add $3,$2,$4 in ID → exactly 1 cycle of PC_stall=IFID_stall=IDEX_bubble=1, then 0; stall_cnt=1.
- lw $5 in EX, beq $5,$0 in ID (pcsrc=001) → stall for 2 consecutive cycles; then branch_taken=1 gives a 1-cycle IFID_flush; flush_cnt=1.
- IDEX_wraddr=0 with IDEX_memrd=1 and IFID_rs=0 → no stall.
- mfhi in ID, md_busy high for 5 cycles → state MD_WAIT, stall for 5 cycles, released on the cycle md_busy falls; irq asserted meanwhile is not taken until RUN.
- irq=1 while ID holds jr (pcsrc=011) → no irq_take. Next instruction has pcsrc=000 → irq_take=IFID_flush=IDEX_bubble=1 for one cycle. irq held high for 10 cycles → no second irq_take. irq low then high again → taken again.
- Drive stall for 2^CNT_W+3 cycles → stall_cnt saturates at all-ones. Then cnt_clr together with a stall → 0. Reset asserted mid-MD_WAIT → RUN, outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Decides each cycle whether PC and IF/ID hold, whether a bubble enters ID/EX,
// and whether IF/ID is flushed.  It covers load-use hazards, branch/jr
// operands not yet forwardable, mult/div waits and interrupt entry.  It also
// keeps saturating stall/flush statistics.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   IFID_*                source regs / rt use / PC source / HI-LO use of ID instr
//   branch_taken          ID-stage redirect decision
//   IDEX_*, EXMEM_*       destination and write/load flags of EX and MEM instrs
//   md_busy               mult/div unit busy
//   irq                   level interrupt request
//   cnt_clr               clear statistics counters
//   PC_stall, IFID_stall  hold PC / IF/ID
//   IDEX_bubble           load a NOP into ID/EX
//   IFID_flush            load a NOP into IF/ID
//   irq_take              PC loads the exception vector, ID PC saved as EPC
//   stall_cnt, flush_cnt  saturating statistics
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             IFID_usert,
  input  logic [2:0]       IFID_pcsrc,
  input  logic             IFID_usehilo,
  input  logic             branch_taken,
  input  logic [4:0]       IDEX_wraddr,
  input  logic             IDEX_regwr,
  input  logic             IDEX_memrd,
  input  logic [4:0]       EXMEM_wraddr,
  input  logic             EXMEM_regwr,
  input  logic             EXMEM_memrd,
  input  logic             md_busy,
  input  logic             irq,
  input  logic             cnt_clr,
  output logic             PC_stall,
  output logic             IFID_stall,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             irq_take,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MD_WAIT, IRQ_WAIT} state_t;

  state_t state_q, state_d;
  logic   post_rst_q;   // first cycle after reset: all controls forced low
  logic   stall, bubble, flush, take;
  logic   lu, br, md, haz;
  logic   rs_ex, rt_ex, rs_mem, rt_mem;

  // Register 0 is never a real producer, so it never matches.
  assign rs_ex  = (IDEX_wraddr  != 5'd0) && (IDEX_wraddr  == IFID_rs);
  assign rt_ex  = (IDEX_wraddr  != 5'd0) && IFID_usert && (IDEX_wraddr  == IFID_rt);
  assign rs_mem = (EXMEM_wraddr != 5'd0) && (EXMEM_wraddr == IFID_rs);
  assign rt_mem = (EXMEM_wraddr != 5'd0) && IFID_usert && (EXMEM_wraddr == IFID_rt);

  assign lu  = IDEX_memrd && (rs_ex || rt_ex);
  // Branch/jr compare happens in ID: an EX result or a MEM-stage load is not
  // yet available to the compare forwarding path.
  assign br  = ((IFID_pcsrc == 3'b001) || (IFID_pcsrc == 3'b011)) &&
               ((IDEX_regwr && (rs_ex || rt_ex)) || (EXMEM_memrd && (rs_mem || rt_mem)));
  assign md  = IFID_usehilo && md_busy;
  assign haz = lu || br || md;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    take    = 1'b0;
    if (reset || post_rst_q) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (haz) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (md && !(lu || br)) state_d = MD_WAIT;
          end else if (irq && (IFID_pcsrc == 3'b000)) begin
            take    = 1'b1;
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = IRQ_WAIT;
          end else if (branch_taken) begin
            flush = 1'b1;
          end
        end
        MD_WAIT: begin
          stall  = md_busy;
          bubble = md_busy;
          if (!md_busy) state_d = RUN;
        end
        IRQ_WAIT: begin
          // md hazards stall here directly rather than via MD_WAIT so that
          // the interrupt block is not lost while waiting on mult/div.
          if (haz) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end else if (branch_taken) begin
            flush = 1'b1;
          end
          state_d = irq ? IRQ_WAIT : RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign PC_stall    = stall;
  assign IFID_stall  = stall;
  assign IDEX_bubble = bubble;
  assign IFID_flush  = flush;
  assign irq_take    = take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      post_rst_q <= 1'b1;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      post_rst_q <= 1'b0;
      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
